// File: rtl/mole_field_ctrl.sv
// Whack-a-mole game engine: N x N hole field with per-hole lifetime timers,
// LFSR spawning, an active-mole cap, hit/miss scoring and a game-over state.
module mole_field_ctrl #(
    parameter int          GRID_N         = 4,
    parameter int          CELL           = 2,
    parameter int          LIFE_TICKS     = 500,
    parameter int          MAX_ACTIVE     = 16,
    parameter int          MAX_MISS       = 9,
    parameter int          SCORE_MAX      = 99,
    parameter int          PENALIZE_WHIFF = 0,
    parameter logic [15:0] SEED           = 16'h0001,
    localparam int         HOLES          = GRID_N * GRID_N,
    localparam int         IDX_W          = $clog2(HOLES),
    localparam int         DISP           = GRID_N * CELL,
    localparam int         ROW_W          = $clog2(DISP),
    localparam int         SCORE_W        = $clog2(SCORE_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic               hit_valid,
    input  logic [IDX_W-1:0]   hit_idx,
    input  logic [ROW_W-1:0]   disp_row,
    output logic [DISP-1:0]    disp_cols,
    output logic [HOLES-1:0]   mole_map,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss,
    output logic               game_over
);

    localparam int LIFE_W  = $clog2(LIFE_TICKS + 1);
    localparam int SUM_W   = IDX_W + 9;
    // A cap above the hole count can never bind, so clamp it to fit the counter.
    localparam int ACT_LIM = (MAX_ACTIVE > HOLES) ? HOLES : MAX_ACTIVE;

    localparam logic [IDX_W:0]     ACT_LIM_C   = (IDX_W + 1)'(ACT_LIM);
    localparam logic [LIFE_W-1:0]  LIFE_C      = LIFE_W'(LIFE_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_MAX_C = SCORE_W'(SCORE_MAX);
    localparam logic [7:0]         MAX_MISS_C  = 8'(MAX_MISS);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    state_t              state_q;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [HOLES-1:0]    moleMap_q, moleMap_d;
    logic [LIFE_W-1:0]   life_q [HOLES];
    logic [LIFE_W-1:0]   life_d [HOLES];
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [7:0]          miss_q, miss_d;
    logic [IDX_W:0]      activeCnt;
    logic [IDX_W:0]      expCnt;
    logic [IDX_W-1:0]    spawnIdx;
    logic                whiff;
    logic [SUM_W-1:0]    missSum;

    // Order matters: expiries first, then the hit (so it overrides a same-hole
    // expiry), then the spawn, which is judged against the pre-cycle field.
    always_comb begin
        lfsr_d    = lfsr_q;
        moleMap_d = moleMap_q;
        life_d    = life_q;
        score_d   = score_q;
        activeCnt = '0;
        expCnt    = '0;
        whiff     = 1'b0;
        spawnIdx  = lfsr_q[IDX_W-1:0];

        if (tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        for (int i = 0; i < HOLES; i++) begin
            activeCnt = activeCnt + {{IDX_W{1'b0}}, moleMap_q[i]};
            if (tick && moleMap_q[i]) begin
                if (life_q[i] == LIFE_W'(1)) begin
                    moleMap_d[i] = 1'b0;
                    life_d[i]    = '0;
                    if (!(hit_valid && (hit_idx == IDX_W'(i)))) begin
                        expCnt = expCnt + (IDX_W + 1)'(1);
                    end
                end else begin
                    life_d[i] = life_q[i] - LIFE_W'(1);
                end
            end
        end

        if (hit_valid) begin
            if (moleMap_q[hit_idx]) begin
                moleMap_d[hit_idx] = 1'b0;
                life_d[hit_idx]    = '0;
                if (score_q != SCORE_MAX_C) begin
                    score_d = score_q + SCORE_W'(1);
                end
            end else begin
                whiff = (PENALIZE_WHIFF != 0);
            end
        end

        if (tick && !moleMap_q[spawnIdx] && (activeCnt < ACT_LIM_C)) begin
            moleMap_d[spawnIdx] = 1'b1;
            life_d[spawnIdx]    = LIFE_C;
        end

        missSum = SUM_W'(miss_q) + SUM_W'(expCnt) + SUM_W'(whiff);
        miss_d  = (missSum > SUM_W'(255)) ? 8'hFF : missSum[7:0];
    end

    // Dropping enable from any state returns to a freshly cleared IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            moleMap_q <= '0;
            score_q   <= '0;
            miss_q    <= '0;
            for (int i = 0; i < HOLES; i++) begin
                life_q[i] <= '0;
            end
        end else if (!enable) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            moleMap_q <= '0;
            score_q   <= '0;
            miss_q    <= '0;
            for (int i = 0; i < HOLES; i++) begin
                life_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= PLAY;
                end
                PLAY: begin
                    if (miss_q >= MAX_MISS_C) begin
                        state_q   <= OVER;
                        moleMap_q <= '0;
                        for (int i = 0; i < HOLES; i++) begin
                            life_q[i] <= '0;
                        end
                    end else begin
                        lfsr_q    <= lfsr_d;
                        moleMap_q <= moleMap_d;
                        life_q    <= life_d;
                        score_q   <= score_d;
                        miss_q    <= miss_d;
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Each hole is a CELL x CELL block; column 0 lands on the MSB side.
    always_comb begin
        disp_cols = '0;
        for (int r = 0; r < GRID_N; r++) begin
            if ((int'(disp_row) / CELL) == r) begin
                for (int c = 0; c < GRID_N; c++) begin
                    for (int j = 0; j < CELL; j++) begin
                        disp_cols[DISP-1-(c*CELL+j)] = moleMap_q[r*GRID_N+c];
                    end
                end
            end
        end
    end

    assign mole_map  = moleMap_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Directed bench for mole_field_ctrl: a default-penalty instance plus a second
// instance with whiff penalty, a cap of two active moles and a score limit of 2.
module tb_mole_field_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        tick;
    logic        hit_valid;
    logic [3:0]  hit_idx;
    logic [2:0]  disp_row;

    logic [7:0]  disp_cols, disp_colsW;
    logic [15:0] mole_map, mole_mapW;
    logic [6:0]  score;
    logic [1:0]  scoreW;
    logic [7:0]  miss, missW;
    logic        game_over, game_overW;

    int nVec;
    int nMis;

    mole_field_ctrl #(
        .GRID_N(4), .CELL(2), .LIFE_TICKS(3), .MAX_ACTIVE(16), .MAX_MISS(3),
        .SCORE_MAX(99), .PENALIZE_WHIFF(0), .SEED(16'h0001)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .disp_row(disp_row),
        .disp_cols(disp_cols), .mole_map(mole_map), .score(score),
        .miss(miss), .game_over(game_over)
    );

    mole_field_ctrl #(
        .GRID_N(4), .CELL(2), .LIFE_TICKS(3), .MAX_ACTIVE(2), .MAX_MISS(3),
        .SCORE_MAX(2), .PENALIZE_WHIFF(1), .SEED(16'h0001)
    ) dutW (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .disp_row(disp_row),
        .disp_cols(disp_colsW), .mole_map(mole_mapW), .score(scoreW),
        .miss(missW), .game_over(game_overW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: inputs change on a falling edge, outputs are
    // sampled on the following falling edge.
    task automatic step(input logic t, input logic h, input logic [3:0] idx);
        tick      = t;
        hit_valid = h;
        hit_idx   = idx;
        @(negedge clk);
        tick      = 1'b0;
        hit_valid = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        step(1'b0, 1'b0, 4'd0);
        enable = 1'b1;
        step(1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL reset_map got=%h exp=%h", mole_map, 16'h0000); end
        nVec++; if (score !== 7'd0) begin nMis++; $display("[TB] FAIL reset_score got=%0d exp=%0d", score, 0); end
        nVec++; if (miss !== 8'd0) begin nMis++; $display("[TB] FAIL reset_miss got=%0d exp=%0d", miss, 0); end
        nVec++; if (game_over !== 1'b0) begin nMis++; $display("[TB] FAIL reset_over got=%b exp=%b", game_over, 1'b0); end
        nVec++; if (disp_cols !== 8'h00) begin nMis++; $display("[TB] FAIL reset_disp got=%b exp=%b", disp_cols, 8'h00); end
        rst = 1'b0;
        @(negedge clk);
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL idle_map got=%h exp=%h", mole_map, 16'h0000); end
    endtask

    task automatic test_spawn();
        restart();
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0002) begin nMis++; $display("[TB] FAIL spawn_map got=%h exp=%h", mole_map, 16'h0002); end
        disp_row = 3'd0; #1;
        nVec++; if (disp_cols !== 8'b0011_0000) begin nMis++; $display("[TB] FAIL disp_row0 got=%b exp=%b", disp_cols, 8'b0011_0000); end
        disp_row = 3'd1; #1;
        nVec++; if (disp_cols !== 8'b0011_0000) begin nMis++; $display("[TB] FAIL disp_row1 got=%b exp=%b", disp_cols, 8'b0011_0000); end
        disp_row = 3'd2; #1;
        nVec++; if (disp_cols !== 8'b0000_0000) begin nMis++; $display("[TB] FAIL disp_row2 got=%b exp=%b", disp_cols, 8'b0000_0000); end
        disp_row = 3'd0;
        @(negedge clk);
    endtask

    task automatic test_hit();
        step(1'b0, 1'b1, 4'd1);
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL hit_map got=%h exp=%h", mole_map, 16'h0000); end
        nVec++; if (score !== 7'd1) begin nMis++; $display("[TB] FAIL hit_score got=%0d exp=%0d", score, 1); end
        nVec++; if (miss !== 8'd0) begin nMis++; $display("[TB] FAIL hit_miss got=%0d exp=%0d", miss, 0); end
        nVec++; if (scoreW !== 2'd1) begin nMis++; $display("[TB] FAIL hit_scoreW got=%0d exp=%0d", scoreW, 1); end
    endtask

    task automatic test_expiry();
        restart();
        nVec++; if (score !== 7'd0) begin nMis++; $display("[TB] FAIL restart_score got=%0d exp=%0d", score, 0); end
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0016) begin nMis++; $display("[TB] FAIL tick3_map got=%h exp=%h", mole_map, 16'h0016); end
        nVec++; if (mole_mapW !== 16'h0006) begin nMis++; $display("[TB] FAIL cap_map got=%h exp=%h", mole_mapW, 16'h0006); end
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0114) begin nMis++; $display("[TB] FAIL tick4_map got=%h exp=%h", mole_map, 16'h0114); end
        nVec++; if (miss !== 8'd1) begin nMis++; $display("[TB] FAIL tick4_miss got=%0d exp=%0d", miss, 1); end
        nVec++; if (missW !== 8'd1) begin nMis++; $display("[TB] FAIL tick4_missW got=%0d exp=%0d", missW, 1); end
        disp_row = 3'd0; #1;
        nVec++; if (disp_cols !== 8'b0000_1100) begin nMis++; $display("[TB] FAIL disp_hole2 got=%b exp=%b", disp_cols, 8'b0000_1100); end
        disp_row = 3'd2; #1;
        nVec++; if (disp_cols !== 8'b1100_0000) begin nMis++; $display("[TB] FAIL disp_hole4 got=%b exp=%b", disp_cols, 8'b1100_0000); end
        disp_row = 3'd5; #1;
        nVec++; if (disp_cols !== 8'b1100_0000) begin nMis++; $display("[TB] FAIL disp_hole8 got=%b exp=%b", disp_cols, 8'b1100_0000); end
        disp_row = 3'd0;
        @(negedge clk);
    endtask

    task automatic test_game_over();
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0111) begin nMis++; $display("[TB] FAIL tick5_map got=%h exp=%h", mole_map, 16'h0111); end
        nVec++; if (miss !== 8'd2) begin nMis++; $display("[TB] FAIL tick5_miss got=%0d exp=%0d", miss, 2); end
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0101) begin nMis++; $display("[TB] FAIL tick6_map got=%h exp=%h", mole_map, 16'h0101); end
        nVec++; if (miss !== 8'd3) begin nMis++; $display("[TB] FAIL tick6_miss got=%0d exp=%0d", miss, 3); end
        nVec++; if (game_over !== 1'b0) begin nMis++; $display("[TB] FAIL over_early got=%b exp=%b", game_over, 1'b0); end
        nVec++; if (missW !== 8'd2) begin nMis++; $display("[TB] FAIL tick6_missW got=%0d exp=%0d", missW, 2); end
        step(1'b0, 1'b0, 4'd0);
        nVec++; if (game_over !== 1'b1) begin nMis++; $display("[TB] FAIL over_set got=%b exp=%b", game_over, 1'b1); end
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL over_map got=%h exp=%h", mole_map, 16'h0000); end
        step(1'b0, 1'b1, 4'd8);
        nVec++; if (score !== 7'd0) begin nMis++; $display("[TB] FAIL over_score got=%0d exp=%0d", score, 0); end
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL over_tick got=%h exp=%h", mole_map, 16'h0000); end
        nVec++; if (miss !== 8'd3) begin nMis++; $display("[TB] FAIL over_miss got=%0d exp=%0d", miss, 3); end
    endtask

    task automatic test_hit_expiry_whiff();
        restart();
        nVec++; if (game_over !== 1'b0) begin nMis++; $display("[TB] FAIL leave_over got=%b exp=%b", game_over, 1'b0); end
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd1);
        nVec++; if (score !== 7'd1) begin nMis++; $display("[TB] FAIL hitexp_score got=%0d exp=%0d", score, 1); end
        nVec++; if (miss !== 8'd0) begin nMis++; $display("[TB] FAIL hitexp_miss got=%0d exp=%0d", miss, 0); end
        nVec++; if (mole_map !== 16'h0114) begin nMis++; $display("[TB] FAIL hitexp_map got=%h exp=%h", mole_map, 16'h0114); end
        nVec++; if (missW !== 8'd0) begin nMis++; $display("[TB] FAIL hitexp_missW got=%0d exp=%0d", missW, 0); end
        step(1'b0, 1'b1, 4'd15);
        nVec++; if (miss !== 8'd0) begin nMis++; $display("[TB] FAIL whiff_miss got=%0d exp=%0d", miss, 0); end
        nVec++; if (missW !== 8'd1) begin nMis++; $display("[TB] FAIL whiff_missW got=%0d exp=%0d", missW, 1); end
        nVec++; if (scoreW !== 2'd1) begin nMis++; $display("[TB] FAIL whiff_scoreW got=%0d exp=%0d", scoreW, 1); end
        step(1'b1, 1'b1, 4'd0);
        nVec++; if (mole_map !== 16'h0111) begin nMis++; $display("[TB] FAIL hitspawn_map got=%h exp=%h", mole_map, 16'h0111); end
        nVec++; if (score !== 7'd1) begin nMis++; $display("[TB] FAIL hitspawn_score got=%0d exp=%0d", score, 1); end
        nVec++; if (miss !== 8'd1) begin nMis++; $display("[TB] FAIL hitspawn_miss got=%0d exp=%0d", miss, 1); end
        nVec++; if (missW !== 8'd3) begin nMis++; $display("[TB] FAIL miss_sumW got=%0d exp=%0d", missW, 3); end
    endtask

    task automatic test_saturation();
        logic [3:0] idxSeq [4];
        idxSeq[0] = 4'd1; idxSeq[1] = 4'd2; idxSeq[2] = 4'd4; idxSeq[3] = 4'd8;
        restart();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'd0);
            step(1'b0, 1'b1, idxSeq[k]);
        end
        nVec++; if (score !== 7'd4) begin nMis++; $display("[TB] FAIL sat_score got=%0d exp=%0d", score, 4); end
        nVec++; if (scoreW !== 2'd2) begin nMis++; $display("[TB] FAIL sat_scoreW got=%0d exp=%0d", scoreW, 2); end
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL sat_map got=%h exp=%h", mole_map, 16'h0000); end
        nVec++; if (miss !== 8'd0) begin nMis++; $display("[TB] FAIL sat_miss got=%0d exp=%0d", miss, 0); end
    endtask

    task automatic test_async_reset();
        restart();
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0004) begin nMis++; $display("[TB] FAIL pre_rst_map got=%h exp=%h", mole_map, 16'h0004); end
        disp_row = 3'd0;
        #2 rst = 1'b1;
        #1;
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL arst_map got=%h exp=%h", mole_map, 16'h0000); end
        nVec++; if (score !== 7'd0) begin nMis++; $display("[TB] FAIL arst_score got=%0d exp=%0d", score, 0); end
        nVec++; if (disp_cols !== 8'h00) begin nMis++; $display("[TB] FAIL arst_disp got=%b exp=%b", disp_cols, 8'h00); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (mole_map !== 16'h0002) begin nMis++; $display("[TB] FAIL arst_respawn got=%h exp=%h", mole_map, 16'h0002); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expMap [3];
        expMap[0] = 16'h0002; expMap[1] = 16'h0006; expMap[2] = 16'h0016;
        step(1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 4'd0);
        nVec++; if (score !== 7'd1) begin nMis++; $display("[TB] FAIL b2b_score got=%0d exp=%0d", score, 1); end
        enable = 1'b0;
        step(1'b0, 1'b0, 4'd0);
        nVec++; if (score !== 7'd0) begin nMis++; $display("[TB] FAIL idle_score got=%0d exp=%0d", score, 0); end
        nVec++; if (mole_map !== 16'h0000) begin nMis++; $display("[TB] FAIL idle_clear got=%h exp=%h", mole_map, 16'h0000); end
        enable = 1'b1;
        step(1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'd0);
            nVec++; if (mole_map !== expMap[k]) begin nMis++; $display("[TB] FAIL replay_%0d got=%h exp=%h", k, mole_map, expMap[k]); end
        end
    endtask

    initial begin
        nVec      = 0;
        nMis      = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        tick      = 1'b0;
        hit_valid = 1'b0;
        hit_idx   = 4'd0;
        disp_row  = 3'd0;
        test_reset();
        test_spawn();
        test_hit();
        test_expiry();
        test_game_over();
        test_hit_expiry_whiff();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
